i2c_txn_arbiter: RTL and testbench

//  Shares one I2C master engine between N_REQ requesters (CPU regs, sensor pollers, EEPROM loader).

---
 rtl/i2c_txn_arbiter_pkg.sv | 25 ++
 rtl/i2c_txn_arbiter_if.sv | 44 ++++
 rtl/i2c_txn_arbiter_rr_pick.sv | 28 ++
 rtl/i2c_txn_arbiter.sv | 149 ++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
// Holds the FSM state encoding, bus field widths and the saturating error-count helper.
package i2c_txn_arbiter_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int ERR_CNT_W  = 16;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RESP,
    ST_ABORT
  } arb_state_t;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and master-engine-side signals of the I2C transaction arbiter.
// 'master' is the arbiter's view (it drives the engine); 'slave' is the environment's view.
interface i2c_txn_arbiter_if
  import i2c_txn_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            req_rw;
  logic [N_REQ*I2C_ADDR_W-1:0] req_addr;
  logic [N_REQ*I2C_DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            rsp_valid;
  logic [I2C_DATA_W-1:0]       rsp_rdata;
  logic                        rsp_err;
  logic                        rsp_timeout;
  logic [ERR_CNT_W-1:0]        err_cnt;

  logic                        m_newd;
  logic                        m_op;
  logic [I2C_ADDR_W-1:0]       m_addr;
  logic [I2C_DATA_W-1:0]       m_din;
  logic                        m_abort;
  logic                        m_busy;
  logic                        m_done;
  logic [I2C_DATA_W-1:0]       m_dout;
  logic                        m_ack_err;

  modport master (
    input  req, req_rw, req_addr, req_wdata,
    output gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_cnt,
    output m_newd, m_op, m_addr, m_din, m_abort,
    input  m_busy, m_done, m_dout, m_ack_err
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata,
    input  gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_cnt,
    input  m_newd, m_op, m_addr, m_din, m_abort,
    output m_busy, m_done, m_dout, m_ack_err
  );

endinterface

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from last_i+1 (mod N_REQ).
// The grant pointer register lives in the parent.
module i2c_txn_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] win_o,
  output logic             any_o
);

  // Scan from the farthest candidate back to the nearest so the nearest hit is assigned last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand  = '0;
    win_o = '0;
    any_o = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_i) + k) % N_REQ);
      if (req_i[cand]) begin
        win_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master engine between N_REQ requesters, one single-byte transaction per grant.
// Round-robin grant, command capture, start pulse, done/watchdog wait, response back to the winner.
module i2c_txn_arbiter
  import i2c_txn_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst,
  i2c_txn_arbiter_if.master bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_t            state_q;
  logic [IDX_W-1:0]      last_gnt_q;
  logic [IDX_W-1:0]      win_q;
  logic [TMR_W-1:0]      timer_q;
  logic [N_REQ-1:0]      gnt_q;
  logic [N_REQ-1:0]      rsp_valid_q;
  logic [I2C_DATA_W-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic                  m_newd_q;
  logic                  m_op_q;
  logic [I2C_ADDR_W-1:0] m_addr_q;
  logic [I2C_DATA_W-1:0] m_din_q;
  logic                  m_abort_q;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  cmd_rw_d;
  logic [I2C_ADDR_W-1:0] cmd_addr_d;
  logic [I2C_DATA_W-1:0] cmd_din_d;
  logic [I2C_DATA_W-1:0] rd_byte_d;
  logic [ERR_CNT_W-1:0]  err_cnt_d;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  i2c_txn_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (bus.req),
    .last_i (last_gnt_q),
    .win_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    cmd_rw_d   = bus.req_rw[pick_idx];
    cmd_addr_d = bus.req_addr[int'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
    cmd_din_d  = bus.req_wdata[int'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
    rd_byte_d  = (m_op_q == OP_READ) ? bus.m_dout : '0;
    err_cnt_d  = err_cnt_inc(err_cnt_q);
  end

  // Outputs are registered: each state's outputs are loaded on the transition into it.
  // The timer counts from the ISSUE cycle, so the abort lands TIMEOUT_CYC cycles after m_newd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_gnt_q    <= IDX_LAST;
      win_q         <= '0;
      timer_q       <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      err_cnt_q     <= '0;
      m_newd_q      <= 1'b0;
      m_op_q        <= OP_WRITE;
      m_addr_q      <= '0;
      m_din_q       <= '0;
      m_abort_q     <= 1'b0;
    end else begin
      m_newd_q      <= 1'b0;
      m_abort_q     <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any && !bus.m_busy) begin
            win_q    <= pick_idx;
            m_op_q   <= cmd_rw_d;
            m_addr_q <= cmd_addr_d;
            m_din_q  <= cmd_din_d;
            gnt_q    <= onehot(pick_idx);
            m_newd_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= timer_q + 1'b1;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.m_done) begin
            rsp_valid_q <= onehot(win_q);
            rsp_rdata_q <= rd_byte_d;
            rsp_err_q   <= bus.m_ack_err;
            if (bus.m_ack_err) err_cnt_q <= err_cnt_d;
            state_q     <= ST_RESP;
          end else if (timer_q == TMR_LAST) begin
            m_abort_q     <= 1'b1;
            rsp_valid_q   <= onehot(win_q);
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            err_cnt_q     <= err_cnt_d;
            state_q       <= ST_ABORT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_RESP, ST_ABORT: begin
          gnt_q      <= '0;
          last_gnt_q <= win_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.m_newd      = m_newd_q;
  assign bus.m_op        = m_op_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_din       = m_din_q;
  assign bus.m_abort     = m_abort_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: directed scenarios plus randomized transactions,
// with a round-robin/response reference model and a simple I2C master-engine model.
module tb_i2c_txn_arbiter;
  import i2c_txn_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 120;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.N_REQ(N)) bus ();

  i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Requester-side stimulus and reference-model state.
  logic [N-1:0] reqv;
  logic [N-1:0] c_rw;
  logic [6:0]   c_addr  [N];
  logic [7:0]   c_wdata [N];
  int           m_last;
  int           m_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive();
    bus.req    = reqv;
    bus.req_rw = c_rw;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[7*i +: 7]  = c_addr[i];
      bus.req_wdata[8*i +: 8] = c_wdata[i];
    end
  endtask

  task automatic rand_cmds();
    for (int i = 0; i < N; i++) begin
      c_rw[i]    = 1'($urandom);
      c_addr[i]  = 7'($urandom);
      c_wdata[i] = 8'($urandom);
    end
    drive();
  endtask

  // Reference rule: first pending requester scanning upward from last+1, wrapping.
  function automatic int model_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.m_busy = 1'b0;
    bus.m_done = 1'b0;
    step();
    step();
    rst    = 1'b0;
    m_last = N - 1;
    m_errs = 0;
  endtask

  // One full transaction: wait for the grant, play the master for 'lat' cycles
  // (lat >= TMO means the master never answers), then check the response.
  task automatic serve(input int lat, input logic ack, input logic [7:0] dout,
                       input bit drop_early, input bit scramble, input bit hold,
                       output int won, output int waited);
    int         exp_i;
    int         rsp_at;
    bit         abort;
    bit         seen;
    logic       exp_rw;
    logic [6:0] exp_addr;
    logic [7:0] exp_din;
    logic [7:0] exp_rd;
    logic       exp_err;
    exp_i  = model_pick(reqv, m_last);
    won    = -1;
    waited = 0;
    seen   = 1'b0;
    for (int s = 1; s <= 40 && !seen; s++) begin
      step();
      waited = s;
      seen   = (bus.m_newd === 1'b1);
    end
    chk("newd_seen", {31'd0, bus.m_newd}, 32'd1);
    if (!seen || exp_i < 0) return;
    for (int i = 0; i < N; i++) if (bus.gnt[i] === 1'b1) won = i;
    exp_rw   = c_rw[exp_i];
    exp_addr = c_addr[exp_i];
    exp_din  = c_wdata[exp_i];
    chk("gnt_issue", {28'd0, bus.gnt}, 32'd1 << exp_i);
    chk("m_op", {31'd0, bus.m_op}, {31'd0, exp_rw});
    chk("m_addr", {25'd0, bus.m_addr}, {25'd0, exp_addr});
    chk("m_din", {24'd0, bus.m_din}, {24'd0, exp_din});
    bus.m_busy = 1'b1;
    if (drop_early) reqv[exp_i] = 1'b0;
    if (scramble) rand_cmds();
    drive();
    abort  = (lat >= TMO);
    rsp_at = abort ? TMO : lat + 1;
    for (int s = 1; s <= rsp_at; s++) begin
      if (!abort && s == rsp_at) begin
        bus.m_done    = 1'b1;
        bus.m_dout    = dout;
        bus.m_ack_err = ack;
        bus.m_busy    = 1'b0;
      end
      step();
      bus.m_done    = 1'b0;
      bus.m_dout    = 8'($urandom);
      bus.m_ack_err = 1'($urandom);
      if (s < rsp_at) begin
        chk("no_early_rsp", {23'd0, bus.rsp_valid, bus.m_abort, bus.m_newd}, 32'd0);
        chk("addr_stable", {25'd0, bus.m_addr}, {25'd0, exp_addr});
      end
    end
    exp_rd  = abort ? 8'h00 : (exp_rw ? dout : 8'h00);
    exp_err = abort | ack;
    if (exp_err && m_errs < 65535) m_errs++;
    chk("rsp_valid", {28'd0, bus.rsp_valid}, 32'd1 << exp_i);
    chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, exp_rd});
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
    chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, abort});
    chk("m_abort", {31'd0, bus.m_abort}, {31'd0, abort});
    chk("err_cnt", {16'd0, bus.err_cnt}, 32'(m_errs));
    chk("gnt_at_rsp", {28'd0, bus.gnt}, 32'd1 << exp_i);
    chk("cmd_held", {24'd0, bus.m_din}, {24'd0, exp_din});
    m_last = exp_i;
    if (!hold) reqv[exp_i] = 1'b0;
    drive();
    if (abort) begin
      for (int s = 0; s < 4; s++) begin
        step();
        chk("settle_idle", {23'd0, bus.gnt, bus.m_newd, bus.rsp_valid}, 32'd0);
      end
      bus.m_busy = 1'b0;
    end else begin
      bus.m_done = 1'($urandom);
      step();
      bus.m_done = 1'b0;
      chk("idle_gap", {23'd0, bus.gnt, bus.m_newd, bus.rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int won;
    int waited;
    int order [6];
    bit seen;
    order = '{0, 1, 2, 3, 0, 1};
    reqv = '0;
    c_rw = '0;
    for (int i = 0; i < N; i++) begin
      c_addr[i]  = '0;
      c_wdata[i] = '0;
    end
    drive();
    bus.m_dout    = '0;
    bus.m_ack_err = 1'b0;
    do_reset();
    step();

    // Reset state
    chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rst_rsp", {28'd0, bus.rsp_valid}, 32'd0);
    chk("rst_pulses", {30'd0, bus.m_newd, bus.m_abort}, 32'd0);
    chk("rst_err_cnt", {16'd0, bus.err_cnt}, 32'd0);
    chk("rst_m_addr", {25'd0, bus.m_addr}, 32'd0);

    // Single write from requester 1, master answers after 100 cycles
    c_rw[1] = OP_WRITE; c_addr[1] = 7'h50; c_wdata[1] = 8'hA5;
    reqv = 4'b0010;
    drive();
    serve(100, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, won, waited);
    chk("grant_latency", 32'(waited), 32'd1);
    chk("t1_winner", 32'(won), 32'd1);

    // Single read from requester 2
    c_rw[2] = OP_READ; c_addr[2] = 7'h12; c_wdata[2] = 8'h00;
    reqv = 4'b0100;
    drive();
    serve(20, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, won, waited);
    chk("t2_winner", 32'(won), 32'd2);

    // All four held continuously: fair rotation from a fresh pointer
    do_reset();
    rand_cmds();
    reqv = 4'b1111;
    drive();
    for (int k = 0; k < 6; k++) begin
      serve(int'($urandom_range(3, 15)), 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b1, won, waited);
      chk("rr_order", 32'(won), 32'(order[k]));
    end
    reqv = '0;
    drive();

    // Three NACKed transactions
    for (int k = 0; k < 3; k++) begin
      rand_cmds();
      reqv = 4'b0001 << $urandom_range(0, N - 1);
      drive();
      serve(int'($urandom_range(2, 30)), 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, won, waited);
    end
    chk("err_cnt_3", {16'd0, bus.err_cnt}, 32'd3);

    // Master never answers: watchdog abort, then the other pending requester goes once idle
    rand_cmds();
    reqv = 4'b0011;
    drive();
    serve(TMO, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, won, waited);
    serve(10, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, won, waited);
    chk("post_abort_lat", 32'(waited), 32'd1);

    // m_done on the very cycle the watchdog would fire wins
    rand_cmds();
    reqv = 4'b1000;
    drive();
    serve(TMO - 1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, won, waited);

    // Reset while waiting for the master
    rand_cmds();
    reqv = 4'b0100;
    drive();
    seen = 1'b0;
    for (int s = 0; s < 40 && !seen; s++) begin
      step();
      seen = (bus.m_newd === 1'b1);
    end
    chk("rst_mid_newd", {31'd0, bus.m_newd}, 32'd1);
    bus.m_busy = 1'b1;
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("rst_mid_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rst_mid_rsp", {28'd0, bus.rsp_valid}, 32'd0);
    chk("rst_mid_abort", {31'd0, bus.m_abort}, 32'd0);
    rst = 1'b0;
    bus.m_busy = 1'b0;
    m_last = N - 1;
    m_errs = 0;
    reqv = 4'b0101;
    drive();
    serve(5, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, won, waited);
    chk("rst_ptr", 32'(won), 32'd0);

    // Randomized traffic: mixed masks, drops, mid-transaction command changes, NACKs, timeouts
    for (int k = 0; k < 14; k++) begin
      rand_cmds();
      reqv = reqv | 4'($urandom_range(1, 15));
      drive();
      serve(($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(1, 40)),
            1'($urandom_range(0, 3) == 0), 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), won, waited);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
